// File: rtl/decode_pipe.sv
// RV32I decode stage: IF/ID register, combinational decode, ID/EX register,
// plus the load-use interlock and branch/jump flush handling.
module decode_pipe #(
    parameter int XLEN      = 32,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            valid_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            valid_o,
    output logic            illegal_o,
    output logic            reg_write_o,
    output logic            mem_write_o,
    output logic            branch_o,
    output logic            jump_o,
    output logic            jalr_o,
    output logic            alu_a_pc_o,
    output logic            alu_src_o,
    output logic [1:0]      result_src_o,
    output logic [3:0]      alu_ctrl_o,
    output logic [2:0]      branch_cond_o,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] pc_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD    = 4'h0;
    localparam logic [3:0] ALU_SUB    = 4'h1;
    localparam logic [3:0] ALU_AND    = 4'h2;
    localparam logic [3:0] ALU_OR     = 4'h3;
    localparam logic [3:0] ALU_XOR    = 4'h4;
    localparam logic [3:0] ALU_SLT    = 4'h5;
    localparam logic [3:0] ALU_SLTU   = 4'h6;
    localparam logic [3:0] ALU_SLL    = 4'h7;
    localparam logic [3:0] ALU_SRL    = 4'h8;
    localparam logic [3:0] ALU_SRA    = 4'h9;
    localparam logic [3:0] ALU_PASS_B = 4'hA;

    logic [31:0]     ifid_instr;
    logic [XLEN-1:0] ifid_pc;
    logic            ifid_valid;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic [4:0] rs1_f, rs2_f, rd_f;

    assign opcode    = ifid_instr[6:0];
    assign funct3    = ifid_instr[14:12];
    assign funct7_b5 = ifid_instr[30];
    assign rs1_f     = ifid_instr[19:15];
    assign rs2_f     = ifid_instr[24:20];
    assign rd_f      = ifid_instr[11:7];

    logic              d_illegal;
    logic              d_reg_write, d_mem_write, d_branch, d_jump, d_jalr;
    logic              d_alu_a_pc, d_alu_src, d_rs1_use, d_rs2_use;
    logic [1:0]        d_result_src;
    logic [3:0]        d_alu_ctrl;
    logic [2:0]        d_branch_cond;
    logic signed [31:0] d_imm32;
    logic [XLEN-1:0]   d_imm;

    // funct7[5] only selects SUB for register ops; for immediates it is imm data
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic f7_b5,
                                          input logic is_reg);
        alu_op = ALU_ADD;
        case (f3)
            3'b000: alu_op = (is_reg && f7_b5) ? ALU_SUB : ALU_ADD;
            3'b001: alu_op = ALU_SLL;
            3'b010: alu_op = ALU_SLT;
            3'b011: alu_op = ALU_SLTU;
            3'b100: alu_op = ALU_XOR;
            3'b101: alu_op = f7_b5 ? ALU_SRA : ALU_SRL;
            3'b110: alu_op = ALU_OR;
            3'b111: alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    endfunction

    always_comb begin
        d_illegal     = 1'b0;
        d_reg_write   = 1'b0;
        d_mem_write   = 1'b0;
        d_branch      = 1'b0;
        d_jump        = 1'b0;
        d_jalr        = 1'b0;
        d_alu_a_pc    = 1'b0;
        d_alu_src     = 1'b0;
        d_rs1_use     = 1'b0;
        d_rs2_use     = 1'b0;
        d_result_src  = 2'b00;
        d_alu_ctrl    = ALU_ADD;
        d_branch_cond = 3'b000;
        d_imm32       = '0;
        case (opcode)
            OP_R: begin
                d_reg_write = 1'b1;
                d_rs1_use   = 1'b1;
                d_rs2_use   = 1'b1;
                d_alu_ctrl  = alu_op(funct3, funct7_b5, 1'b1);
            end
            OP_I: begin
                d_reg_write = 1'b1;
                d_alu_src   = 1'b1;
                d_rs1_use   = 1'b1;
                d_alu_ctrl  = alu_op(funct3, funct7_b5, 1'b0);
                d_imm32     = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
            end
            OP_LOAD: begin
                d_reg_write  = 1'b1;
                d_alu_src    = 1'b1;
                d_rs1_use    = 1'b1;
                d_result_src = 2'b01;
                d_imm32      = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
            end
            OP_STORE: begin
                d_mem_write = 1'b1;
                d_alu_src   = 1'b1;
                d_rs1_use   = 1'b1;
                d_rs2_use   = 1'b1;
                d_imm32     = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
            end
            OP_BRANCH: begin
                d_branch      = 1'b1;
                d_rs1_use     = 1'b1;
                d_rs2_use     = 1'b1;
                d_branch_cond = funct3;
                case (funct3[2:1])
                    2'b10:   d_alu_ctrl = ALU_SLT;
                    2'b11:   d_alu_ctrl = ALU_SLTU;
                    default: d_alu_ctrl = ALU_SUB;
                endcase
                d_imm32 = {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                           ifid_instr[30:25], ifid_instr[11:8], 1'b0};
            end
            OP_JAL: begin
                d_reg_write  = 1'b1;
                d_jump       = 1'b1;
                d_result_src = 2'b10;
                d_imm32      = {{11{ifid_instr[31]}}, ifid_instr[31], ifid_instr[19:12],
                                ifid_instr[20], ifid_instr[30:21], 1'b0};
            end
            OP_JALR: begin
                d_reg_write  = 1'b1;
                d_jalr       = 1'b1;
                d_alu_src    = 1'b1;
                d_rs1_use    = 1'b1;
                d_result_src = 2'b10;
                d_imm32      = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
            end
            OP_LUI: begin
                d_reg_write = 1'b1;
                d_alu_src   = 1'b1;
                d_alu_ctrl  = ALU_PASS_B;
                d_imm32     = {ifid_instr[31:12], 12'b0};
            end
            OP_AUIPC: begin
                d_reg_write = 1'b1;
                d_alu_src   = 1'b1;
                d_alu_a_pc  = 1'b1;
                d_imm32     = {ifid_instr[31:12], 12'b0};
            end
            default: d_illegal = 1'b1;
        endcase
    end

    assign d_imm = XLEN'(d_imm32);

    logic load_use, hazard, advance, ex_load, ex_illegal;

    assign load_use = valid_o && (result_src_o == 2'b01) && (rd_o != 5'd0) &&
                      ((d_rs1_use && (rs1_f == rd_o)) || (d_rs2_use && (rs2_f == rd_o)));
    assign hazard   = HAZARD_EN && ifid_valid && load_use;
    assign stall_o  = hazard && !flush_i;

    assign advance    = !flush_i && !hazard && ifid_valid;
    assign ex_load    = advance && !d_illegal;
    assign ex_illegal = advance && d_illegal;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ifid_instr    <= '0;
            ifid_pc       <= '0;
            ifid_valid    <= 1'b0;
            valid_o       <= 1'b0;
            illegal_o     <= 1'b0;
            reg_write_o   <= 1'b0;
            mem_write_o   <= 1'b0;
            branch_o      <= 1'b0;
            jump_o        <= 1'b0;
            jalr_o        <= 1'b0;
            alu_a_pc_o    <= 1'b0;
            alu_src_o     <= 1'b0;
            result_src_o  <= 2'b00;
            alu_ctrl_o    <= 4'h0;
            branch_cond_o <= 3'b000;
            imm_o         <= '0;
            pc_o          <= '0;
            rs1_o         <= 5'd0;
            rs2_o         <= 5'd0;
            rd_o          <= 5'd0;
        end else begin
            // flush drops the fetched slot; a hazard holds it for one more cycle
            if (flush_i) begin
                ifid_valid <= 1'b0;
            end else if (!hazard) begin
                ifid_instr <= instr_i;
                ifid_pc    <= pc_i;
                ifid_valid <= valid_i;
            end
            valid_o       <= ex_load;
            illegal_o     <= ex_illegal;
            reg_write_o   <= ex_load && d_reg_write;
            mem_write_o   <= ex_load && d_mem_write;
            branch_o      <= ex_load && d_branch;
            jump_o        <= ex_load && d_jump;
            jalr_o        <= ex_load && d_jalr;
            alu_a_pc_o    <= ex_load && d_alu_a_pc;
            alu_src_o     <= ex_load && d_alu_src;
            result_src_o  <= ex_load ? d_result_src : 2'b00;
            alu_ctrl_o    <= ex_load ? d_alu_ctrl : 4'h0;
            branch_cond_o <= ex_load ? d_branch_cond : 3'b000;
            imm_o         <= ex_load ? d_imm : '0;
            pc_o          <= ex_load ? ifid_pc : '0;
            rs1_o         <= (ex_load && d_rs1_use) ? rs1_f : 5'd0;
            rs2_o         <= (ex_load && d_rs2_use) ? rs2_f : 5'd0;
            rd_o          <= (ex_load && d_reg_write) ? rd_f : 5'd0;
        end
    end

endmodule
